// File: rtl/decoder_3_to_8_en_if.sv
// Select-decoder signal bundle: 3-bit index, enable, and the eight one-hot selects.
interface decoder_3_to_8_en_if;
  logic x0;
  logic x1;
  logic x2;
  logic en;
  logic Y0;
  logic Y1;
  logic Y2;
  logic Y3;
  logic Y4;
  logic Y5;
  logic Y6;
  logic Y7;

  modport master (
    output x0, x1, x2, en,
    input  Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7
  );

  modport slave (
    input  x0, x1, x2, en,
    output Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7
  );
endinterface

// File: rtl/decoder_3_to_8_en.sv
// 3-to-8 one-hot select generator with enable; outputs optionally registered
// (async active-low clear) or passed straight through combinationally.
module decoder_3_to_8_en #(
  parameter bit OUT_REG = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  decoder_3_to_8_en_if.slave  bus
);

  function automatic logic [7:0] decode(input logic enable, input logic [2:0] idx);
    logic [7:0] sel;
    sel = 8'b0;
    if (enable) sel[idx] = 1'b1;
    return sel;
  endfunction

  logic [2:0] idx_p0;
  logic [7:0] y_next_p0;
  logic [7:0] y_p1;

  always_comb begin
    idx_p0    = {bus.x2, bus.x1, bus.x0};
    y_next_p0 = decode(bus.en, idx_p0);
  end

  // p0 -> p1: output register, or a wire in the bypass build
  generate
    if (OUT_REG) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_p1 <= 8'b0;
        else        y_p1 <= y_next_p0;
      end
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign y_p1 = y_next_p0;
    end
  endgenerate

  assign bus.Y0 = y_p1[0];
  assign bus.Y1 = y_p1[1];
  assign bus.Y2 = y_p1[2];
  assign bus.Y3 = y_p1[3];
  assign bus.Y4 = y_p1[4];
  assign bus.Y5 = y_p1[5];
  assign bus.Y6 = y_p1[6];
  assign bus.Y7 = y_p1[7];

endmodule

// File: tb/tb_decoder_3_to_8_en.sv
// Bench for the registered and the combinational decoder builds against a select-index model.
module tb_decoder_3_to_8_en;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  decoder_3_to_8_en_if bus_r ();
  decoder_3_to_8_en_if bus_c ();

  decoder_3_to_8_en #(.OUT_REG(1'b1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r));
  decoder_3_to_8_en #(.OUT_REG(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  logic [7:0] y_r;
  logic [7:0] y_c;
  assign y_r = {bus_r.Y7, bus_r.Y6, bus_r.Y5, bus_r.Y4, bus_r.Y3, bus_r.Y2, bus_r.Y1, bus_r.Y0};
  assign y_c = {bus_c.Y7, bus_c.Y6, bus_c.Y5, bus_c.Y4, bus_c.Y3, bus_c.Y2, bus_c.Y1, bus_c.Y0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected select word: the bit whose position equals the index, if enabled.
  function automatic logic [7:0] ref_sel(input bit enable, input int idx);
    return enable ? 8'(1 << idx) : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_r(input bit enable, input int idx);
    bus_r.en = enable;
    {bus_r.x2, bus_r.x1, bus_r.x0} = 3'(idx);
  endtask

  task automatic drive_c(input bit enable, input int idx);
    bus_c.en = enable;
    {bus_c.x2, bus_c.x1, bus_c.x0} = 3'(idx);
  endtask

  // Apply inputs after a falling edge, check one edge later, then disturb the
  // inputs between edges and confirm the registered outputs hold.
  task automatic step_r(input string tag, input bit enable, input int idx);
    logic [7:0] exp;
    @(negedge clk);
    drive_r(enable, idx);
    @(posedge clk);
    #1;
    exp = ref_sel(enable, idx);
    chk(tag, y_r, exp);
    chk({tag, "_pop"}, 8'($countones(y_r)), enable ? 8'd1 : 8'd0);
    #1;
    drive_r(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    #1;
    chk({tag, "_hold"}, y_r, exp);
  endtask

  task automatic step_c(input string tag, input bit enable, input int idx);
    drive_c(enable, idx);
    #1;
    chk(tag, y_c, ref_sel(enable, idx));
    chk({tag, "_pop"}, 8'($countones(y_c)), enable ? 8'd1 : 8'd0);
    #4;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive_r(1'b1, 5);
    drive_c(1'b0, 0);

    // Reset held with an active decode pending
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", y_r, 8'h00);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release", y_r, 8'h20);

    for (int i = 0; i < 8; i++) step_r("en_off", 1'b0, i);
    for (int i = 0; i < 8; i++) step_r("en_on", 1'b1, i);

    step_r("toggle_1", 1'b1, 2);
    step_r("toggle_0", 1'b0, 2);
    step_r("toggle_1b", 1'b1, 2);

    // Asynchronous clear between edges
    step_r("pre_async", 1'b1, 6);
    @(negedge clk);
    drive_r(1'b1, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clr", y_r, 8'h00);
    @(negedge clk);
    chk("async_low", y_r, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("async_wait", y_r, 8'h00);
    @(posedge clk);
    #1;
    chk("async_rel", y_r, 8'h40);

    for (int k = 0; k < 200; k++)
      step_r("rand_r", bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)));

    // Combinational build
    for (int i = 0; i < 8; i++) step_c("c_on", 1'b1, i);
    for (int i = 0; i < 8; i++) step_c("c_off", 1'b0, i);
    rst_n = 1'b0;
    step_c("c_rst_ignored", 1'b1, 3);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++)
      step_c("rand_c", bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
